// File: rtl/ram_test_pkg.sv
// Shared state encodings, default widths and the test-pattern function for the RAM test engine.
package ram_test_pkg;

  localparam int unsigned AddrWDef = 5;
  localparam int unsigned DataWDef = 8;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  // Full-width result; callers keep the low DATA_W bits, so the add wraps modulo 2**DATA_W.
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed,
                                          input logic inv);
    logic [31:0] sum;
    sum = addr + seed;
    return inv ? ~sum : sum;
  endfunction

endpackage

// File: rtl/ram_rd_checker.sv
// Read-back checker: aligns the expected word with the registered RAM output one cycle later,
// counts mismatches (saturating) and records the address of the first one.
module ram_rd_checker
  import ram_test_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              rd_issue_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_exp_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [ADDR_W+1:0] err_cnt_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  localparam int unsigned CntW = ADDR_W + 2;

  logic              rd_vld_q;
  logic [DATA_W-1:0] exp_data_q;
  logic [ADDR_W-1:0] exp_addr_q;
  logic [CntW-1:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              mismatch;

  always_comb begin
    mismatch   = rd_vld_q && (ram_rdata_i != exp_data_q);
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (clr_i) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CntW'(1);
      if (err_cnt_q == '0) err_addr_d = exp_addr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_q   <= 1'b0;
      exp_data_q <= '0;
      exp_addr_q <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      rd_vld_q   <= rd_issue_i;
      exp_data_q <= rd_exp_i;
      exp_addr_q <= rd_addr_i;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: rtl/ram_wr_test.sv
// RAM write/read-back test engine: fills the RAM with (addr + SEED), reads it back and reports.
// Optional RAM_TEST_INV_PASS_EN adds a second fill/check pass with the inverted pattern.
module ram_wr_test
  import ram_test_pkg::*;
#(
  parameter int unsigned       ADDR_W = AddrWDef,
  parameter int unsigned       DATA_W = DataWDef,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'h5A)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W+1:0] err_cnt_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_q, pass_d;
  logic              start_acc;
  logic              inv;
  logic              last_addr;
  logic [31:0]       pat_full;
  logic              unused_pat;

`ifdef RAM_TEST_INV_PASS_EN
  logic pass_sel_q, pass_sel_d;
  assign inv = pass_sel_q;
`else
  assign inv = 1'b0;
`endif

  assign last_addr = (addr_q == '1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pass_d    = pass_q;
    start_acc = 1'b0;
`ifdef RAM_TEST_INV_PASS_EN
    pass_sel_d = pass_sel_q;
`endif
    case (state_q)
      StIdle: begin
        addr_d = '0;
        if (start_i) begin
          start_acc = 1'b1;
          pass_d    = 1'b0;
          state_d   = StWrite;
`ifdef RAM_TEST_INV_PASS_EN
          pass_sel_d = 1'b0;
`endif
        end
      end
      // Address wraps to 0 on its own when leaving WRITE and READ.
      StWrite: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr) state_d = StRead;
      end
      StRead: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr) state_d = StDrain;
      end
      StDrain: begin
        addr_d  = '0;
        state_d = StDone;
`ifdef RAM_TEST_INV_PASS_EN
        if (!pass_sel_q) begin
          pass_sel_d = 1'b1;
          state_d    = StWrite;
        end
`endif
      end
      StDone: begin
        pass_d  = (err_cnt_o == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      pass_q  <= 1'b0;
`ifdef RAM_TEST_INV_PASS_EN
      pass_sel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
`ifdef RAM_TEST_INV_PASS_EN
      pass_sel_q <= pass_sel_d;
`endif
    end
  end

  assign pat_full    = pattern(32'(addr_q), 32'(SEED), inv);
  assign unused_pat  = ^pat_full[31:DATA_W];
  assign ram_addr_o  = addr_q;
  assign ram_we_o    = (state_q == StWrite);
  assign ram_wdata_o = ram_we_o ? pat_full[DATA_W-1:0] : '0;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  // Result is visible alongside done, then held in pass_q until the next start.
  assign pass_o      = done_o ? (err_cnt_o == '0) : pass_q;

  ram_rd_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (start_acc),
    .rd_issue_i (state_q == StRead),
    .rd_addr_i  (addr_q),
    .rd_exp_i   (pat_full[DATA_W-1:0]),
    .ram_rdata_i(ram_rdata_i),
    .err_cnt_o  (err_cnt_o),
    .err_addr_o (err_addr_o)
  );

endmodule
